strb_lane_encoder: RTL and testbench

- Upstream stage of var_fifo.
- Accepts full-width beats qualified by a per-lane strobe mask.
- Converts each contiguous strobe mask into the start-lane / lane-count form var_fifo consumes on its data-in side.
- Buffers results in a 2-entry registered skid buffer, so no combinational path runs from ready_i to ready_o. Zero-strobe and non-contiguous beats are consumed and dropped; non-contiguous beats are flagged.

---
 rtl/strb_lane_encoder.sv | 155 +++++++++++++++
 tb/tb_strb_lane_encoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strb_lane_encoder.sv
// Strobe-mask to start-lane/lane-count encoder feeding var_fifo.
// Contiguous beats go into a 2-entry registered skid buffer; other beats are dropped and non-contiguous ones are flagged.
module strb_lane_encoder #(
    parameter int ElemWidth   = 4,
    parameter int NumElem     = 4,
    parameter int ErrCntWidth = 8,
    localparam int LaneW      = $clog2(NumElem),
    localparam int CntW       = $clog2(NumElem + 1)
) (
    input  logic                               clk_i,
    input  logic                               arst_ni,
    input  logic [NumElem-1:0][ElemWidth-1:0]  data_i,
    input  logic [NumElem-1:0]                 strb_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [NumElem-1:0][ElemWidth-1:0]  data_o,
    output logic [LaneW-1:0]                   start_lane_o,
    output logic [CntW-1:0]                    num_lanes_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               err_o,
    output logic [ErrCntWidth-1:0]             err_count_o
);

    // A mask is contiguous when it contains exactly one rising edge of set bits.
    function automatic logic is_contig(input logic [NumElem-1:0] strb);
        int unsigned runs;
        logic        prev;
        runs = 0;
        prev = 1'b0;
        for (int i = 0; i < NumElem; i++) begin
            runs = runs + ((strb[i] && !prev) ? 1 : 0);
            prev = strb[i];
        end
        return (runs == 1);
    endfunction

    function automatic logic [LaneW-1:0] lowest_lane(input logic [NumElem-1:0] strb);
        logic [LaneW-1:0] idx;
        idx = {LaneW{1'b0}};
        for (int i = NumElem - 1; i >= 0; i--) begin
            idx = strb[i] ? LaneW'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [CntW-1:0] pop_count(input logic [NumElem-1:0] strb);
        logic [CntW-1:0] cnt;
        cnt = {CntW{1'b0}};
        for (int i = 0; i < NumElem; i++) begin
            cnt = cnt + CntW'(strb[i]);
        end
        return cnt;
    endfunction

    function automatic logic [NumElem-1:0][ElemWidth-1:0] mask_lanes(
        input logic [NumElem-1:0][ElemWidth-1:0] data,
        input logic [NumElem-1:0]                strb
    );
        logic [NumElem-1:0][ElemWidth-1:0] res;
        for (int i = 0; i < NumElem; i++) begin
            res[i] = strb[i] ? data[i] : {ElemWidth{1'b0}};
        end
        return res;
    endfunction

    logic                               out_valid_r;
    logic [NumElem-1:0][ElemWidth-1:0]  out_data_r;
    logic [LaneW-1:0]                   out_start_r;
    logic [CntW-1:0]                    out_num_r;
    logic                               skid_valid_r;
    logic [NumElem-1:0][ElemWidth-1:0]  skid_data_r;
    logic [LaneW-1:0]                   skid_start_r;
    logic [CntW-1:0]                    skid_num_r;
    logic                               err_r;
    logic [ErrCntWidth-1:0]             err_count_r;

    logic                               fire_s;
    logic                               contig_s;
    logic                               push_s;
    logic                               bad_s;
    logic                               pop_s;
    logic [NumElem-1:0][ElemWidth-1:0]  new_data_s;
    logic [LaneW-1:0]                   new_start_s;
    logic [CntW-1:0]                    new_num_s;

    // Skid is only ever filled while the head is occupied, so it alone marks occupancy 2.
    assign ready_o      = ~skid_valid_r;
    assign valid_o      = out_valid_r;
    assign data_o       = out_data_r;
    assign start_lane_o = out_start_r;
    assign num_lanes_o  = out_num_r;
    assign err_o        = err_r;
    assign err_count_o  = err_count_r;

    // Classify the offered beat and build its encoded buffer entry.
    always_comb begin
        fire_s      = valid_i & ready_o;
        contig_s    = is_contig(strb_i);
        push_s      = fire_s & contig_s;
        bad_s       = fire_s & (strb_i != {NumElem{1'b0}}) & ~contig_s;
        pop_s       = out_valid_r & ready_i;
        new_data_s  = mask_lanes(data_i, strb_i);
        new_start_s = lowest_lane(strb_i);
        new_num_s   = pop_count(strb_i);
    end

    // Head/skid buffer: head refills from skid first to keep FIFO order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_start_r  <= {LaneW{1'b0}};
            out_num_r    <= {CntW{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_start_r <= {LaneW{1'b0}};
            skid_num_r   <= {CntW{1'b0}};
        end else if (!out_valid_r || pop_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= skid_data_r;
                out_start_r  <= skid_start_r;
                out_num_r    <= skid_num_r;
                skid_valid_r <= 1'b0;
            end else if (push_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= new_data_s;
                out_start_r <= new_start_s;
                out_num_r   <= new_num_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (push_s) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= new_data_s;
            skid_start_r <= new_start_s;
            skid_num_r   <= new_num_s;
        end
    end

    // Error pulse and saturating error counter for non-contiguous beats.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_r       <= 1'b0;
            err_count_r <= {ErrCntWidth{1'b0}};
        end else begin
            err_r <= bad_s;
            if (bad_s && (err_count_r != {ErrCntWidth{1'b1}})) begin
                err_count_r <= err_count_r + {{(ErrCntWidth-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_strb_lane_encoder.sv
// Scoreboard bench for strb_lane_encoder: a negedge monitor predicts pushes/errors and checks every popped beat.
module tb_strb_lane_encoder;
    localparam int EW = 4;
    localparam int NE = 4;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 arst_ni = 1'b0;
    logic [NE-1:0][EW-1:0] data_i;
    logic [NE-1:0]        strb_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [NE-1:0][EW-1:0] data_o;
    logic [1:0]           start_lane_o;
    logic [2:0]           num_lanes_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 err_o;
    logic [CW-1:0]        err_count_o;

    strb_lane_encoder #(.ElemWidth(EW), .NumElem(NE), .ErrCntWidth(CW)) dut (
        .clk_i(clk), .arst_ni(arst_ni), .data_i(data_i), .strb_i(strb_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
        .start_lane_o(start_lane_o), .num_lanes_o(num_lanes_o), .valid_o(valid_o),
        .ready_i(ready_i), .err_o(err_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  s;
        logic [2:0]  n;
    } beat_t;

    beat_t q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_0101 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit contig(input logic [3:0] s);
        logic [4:0] v;
        if (s == 4'b0000) return 1'b0;
        v = {1'b0, s};
        for (int k = 0; k < 4; k++) if (!v[0]) v = v >> 1;
        return ((v & (v + 5'd1)) == 5'd0);
    endfunction

    function automatic beat_t model(input logic [15:0] d, input logic [3:0] s);
        beat_t b;
        int    lo;
        lo = 0;
        for (int l = 3; l >= 0; l--) if (s[l]) lo = l;
        b.s = 2'(lo);
        b.n = 3'($countones(s));
        b.d = 16'h0000;
        for (int l = 0; l < 4; l++) if (s[l]) b.d[l*4 +: 4] = d[l*4 +: 4];
        return b;
    endfunction

    // Monitor: check pops against the queue, errors against the model, and stalled outputs for stability.
    logic        err_pend = 1'b0;
    logic [7:0]  cnt_m = 8'h00;
    logic        stall_prev = 1'b0;
    logic [22:0] held;
    always @(negedge clk) begin
        if (!arst_ni) begin
            q.delete();
            err_pend   = 1'b0;
            cnt_m      = 8'h00;
            stall_prev = 1'b0;
        end else begin
            chk("err_o", err_o, err_pend);
            if (err_pend && cnt_m != 8'hff) cnt_m = cnt_m + 8'h01;
            chk("err_count", err_count_o, cnt_m);
            if (stall_prev) chk("stall_hold", {valid_o, data_o, start_lane_o, num_lanes_o}, {1'b1, held[20:0]});
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1'b1, 1'b0);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    chk("out_data", data_o, b.d);
                    chk("out_start", start_lane_o, b.s);
                    chk("out_num", num_lanes_o, b.n);
                end
            end
            stall_prev = valid_o && !ready_i;
            held = {2'b00, data_o, start_lane_o, num_lanes_o};
            err_pend = 1'b0;
            if (valid_i && ready_o && strb_i != 4'b0000) begin
                if (contig(strb_i)) q.push_back(model(data_i, strb_i));
                else err_pend = 1'b1;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [3:0] s, input bit rnd);
        bit acc;
        bit ok;
        ok = 1'b0;
        data_i  = d;
        strb_i  = s;
        valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 1'b0, 1'b1);
        valid_i = 1'b0;
    endtask

    task automatic dir(input logic [15:0] d, input logic [3:0] s,
                       input logic [15:0] ed, input logic [1:0] es, input logic [2:0] en);
        send(d, s, 1'b0);
        chk("dir_valid", valid_o, 1'b1);
        chk("dir_data", data_o, ed);
        chk("dir_start", start_lane_o, es);
        chk("dir_num", num_lanes_o, en);
    endtask

    function automatic logic [3:0] rnd_contig();
        int lo;
        int n;
        lo = $urandom_range(0, 3);
        n  = $urandom_range(1, 4 - lo);
        return 4'(((1 << n) - 1) << lo);
    endfunction

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk(tag, q.size(), 0);
    endtask

    logic [3:0] bad_pat [5] = '{4'b0101, 4'b1001, 4'b1010, 4'b1011, 4'b1101};

    initial begin
        valid_i = 1'b0;
        ready_i = 1'b1;
        strb_i  = 4'b0000;
        data_i  = 16'h0000;
        #7;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_data", data_o, 16'h0000);
        chk("rst_start", start_lane_o, 2'd0);
        chk("rst_num", num_lanes_o, 3'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cnt", err_count_o, 8'h00);
        #5 arst_ni = 1'b1;
        @(posedge clk); #1;

        dir(16'hdcba, 4'b0110, 16'h0cb0, 2'd1, 3'd2);
        dir(16'h89fe, 4'b1110, 16'h89f0, 2'd1, 3'd3);
        dir(16'h4567, 4'b0111, 16'h0567, 2'd0, 3'd3);
        dir(16'h1234, 4'b1111, 16'h1234, 2'd0, 3'd4);

        chk("drop_cnt0", err_count_o, 8'h00);
        send(16'hffff, 4'b0000, 1'b0);
        chk("zero_valid", valid_o, 1'b0);
        chk("zero_err", err_o, 1'b0);
        send(16'hffff, 4'b0101, 1'b0);
        chk("nc_valid", valid_o, 1'b0);
        chk("nc_err", err_o, 1'b1);
        chk("nc_cnt", err_count_o, 8'h01);
        @(posedge clk); #1;
        chk("nc_err_clr", err_o, 1'b0);

        for (int i = 0; i < 256; i++) send(16'($urandom), bad_pat[i % 5], 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("sat_cnt", err_count_o, 8'hff);

        ready_i = 1'b0;
        send(16'h1111, 4'b0011, 1'b0);
        send(16'h2222, 4'b1100, 1'b0);
        chk("bp_rdy_low", ready_o, 1'b0);
        data_i  = 16'h3333;
        strb_i  = 4'b0110;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy_held", ready_o, 1'b0);
            chk("bp_head", data_o, 16'h0011);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        send(16'h3333, 4'b0110, 1'b0);
        drain("bp_drain");

        for (int i = 0; i < 16; i++) begin
            send(16'($urandom), rnd_contig(), 1'b0);
            chk("st_rdy", ready_o, 1'b1);
            chk("st_vld", valid_o, 1'b1);
        end
        drain("st_drain");

        send(16'h0000, 4'b0101, 1'b0);
        ready_i = 1'b0;
        send(16'haaaa, 4'b0001, 1'b0);
        send(16'hbbbb, 4'b1000, 1'b0);
        #2 arst_ni = 1'b0;
        #1;
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_ready", ready_o, 1'b1);
        chk("arst_cnt", err_count_o, 8'h00);
        #4 arst_ni = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b1;
        dir(16'hdcba, 4'b0110, 16'h0cb0, 2'd1, 3'd2);

        for (int i = 0; i < 60; i++) begin
            case (i % 3)
                0: send(16'($urandom), rnd_contig(), 1'b1);
                1: begin
                    send(16'($urandom), 4'b0101, 1'b1);
                    n_0101++;
                end
                default: send(16'($urandom), 4'b0000, 1'b1);
            endcase
        end
        ready_i = 1'b1;
        drain("mix_drain");
        repeat (2) @(posedge clk);
        #1 chk("mix_errcnt", err_count_o, 8'(n_0101));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
